// File: rtl/arm_pipe_pkg.sv
// Shared types and default constants for the ARM pipeline stall control logic.
package arm_pipe_pkg;

   localparam int unsigned MEM_TIMEOUT_DEF = 255;
   localparam int unsigned WAIT_W_DEF      = 8;
   localparam int unsigned CNT_W_DEF       = 32;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } pipe_state_e;

   typedef struct packed {
      logic freeze_if;
      logic bubble_id;
      logic flush;
      logic freeze_all;
   } pipe_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that increments once per cycle with inc high and holds at all-ones.
module sat_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Freeze/bubble/flush generation with a memory-wait FSM and sticky watchdog.
// Statistics counters and their ports exist only when PIPE_STALL_CNT_EN is defined.
module pipeline_stall_controller
   import arm_pipe_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int unsigned WAIT_W      = WAIT_W_DEF
`ifdef PIPE_STALL_CNT_EN
   ,
   parameter int unsigned CNT_W       = CNT_W_DEF
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hazard,
   input  logic             branch_taken,
   input  logic             mem_r_en,
   input  logic             mem_w_en,
   input  logic             mem_ready,
   output logic             freeze_if,
   output logic             bubble_id,
   output logic             flush,
   output logic             freeze_all,
   output logic             mem_timeout
`ifdef PIPE_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0] hazard_stall_cnt,
   output logic [CNT_W-1:0] mem_stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);

   localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);

   pipe_state_e       state_q;
   pipe_state_e       state_d;
   logic [WAIT_W-1:0] wait_q;
   logic [WAIT_W-1:0] wait_d;
   logic              timeout_q;
   logic              timeout_d;
   logic              mem_req;
   logic              mstall;
   pipe_ctrl_t        ctrl;

   // Registered state: FSM, consecutive-stall counter, sticky watchdog flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= RUN;
         wait_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         timeout_q <= timeout_d;
      end
   end

   // The wait counter tallies every stalled cycle, including the first one seen
   // in RUN, so it equals N at the edge ending the N-th consecutive stall.
   always_comb begin
      state_d = state_q;
      wait_d  = '0;
      mstall  = 1'b0;
      mem_req = mem_r_en | mem_w_en;
      case (state_q)
         RUN: begin
            if (mem_req && !mem_ready) begin
               state_d = MEM_WAIT;
               mstall  = 1'b1;
               wait_d  = WAIT_W'(1);
            end
         end
         MEM_WAIT: begin
            if (mem_ready) begin
               state_d = RUN;
            end else begin
               mstall = 1'b1;
               wait_d = (wait_q == TIMEOUT_VAL) ? wait_q : wait_q + WAIT_W'(1);
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
      // Outputs are held low for as long as reset is asserted.
      mstall    = mstall & rst;
      timeout_d = timeout_q | (mstall && (wait_d == TIMEOUT_VAL));
   end

   // Priority: memory stall over branch flush over hazard bubble.
   always_comb begin
      ctrl            = '0;
      ctrl.freeze_all = mstall;
      ctrl.flush      = rst & branch_taken & ~mstall;
      ctrl.bubble_id  = rst & hazard & ~branch_taken & ~mstall;
      ctrl.freeze_if  = mstall | ctrl.bubble_id;
   end

   assign freeze_if   = ctrl.freeze_if;
   assign bubble_id   = ctrl.bubble_id;
   assign flush       = ctrl.flush;
   assign freeze_all  = ctrl.freeze_all;
   assign mem_timeout = timeout_q;

`ifdef PIPE_STALL_CNT_EN
   sat_counter #(.WIDTH(CNT_W)) u_hazard_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (ctrl.bubble_id),
      .count (hazard_stall_cnt)
   );

   sat_counter #(.WIDTH(CNT_W)) u_mem_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (ctrl.freeze_all),
      .count (mem_stall_cnt)
   );

   sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (ctrl.flush),
      .count (flush_cnt)
   );
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: directed scenarios then random traffic.
module tb_pipeline_stall_controller;

   localparam int unsigned T_OUT = 4;
   localparam int unsigned WW    = 3;

   logic clk          = 1'b0;
   logic rst          = 1'b0;
   logic hazard       = 1'b0;
   logic branch_taken = 1'b0;
   logic mem_r_en     = 1'b0;
   logic mem_w_en     = 1'b0;
   logic mem_ready    = 1'b0;
   logic freeze_if;
   logic bubble_id;
   logic flush;
   logic freeze_all;
   logic mem_timeout;
`ifdef PIPE_STALL_CNT_EN
   logic [31:0] hazard_stall_cnt;
   logic [31:0] mem_stall_cnt;
   logic [31:0] flush_cnt;
`endif

   pipeline_stall_controller #(
      .MEM_TIMEOUT (T_OUT),
      .WAIT_W      (WW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .hazard       (hazard),
      .branch_taken (branch_taken),
      .mem_r_en     (mem_r_en),
      .mem_w_en     (mem_w_en),
      .mem_ready    (mem_ready),
      .freeze_if    (freeze_if),
      .bubble_id    (bubble_id),
      .flush        (flush),
      .freeze_all   (freeze_all),
      .mem_timeout  (mem_timeout)
`ifdef PIPE_STALL_CNT_EN
      ,
      .hazard_stall_cnt (hazard_stall_cnt),
      .mem_stall_cnt    (mem_stall_cnt),
      .flush_cnt        (flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        fif;
      logic        bid;
      logic        fl;
      logic        fa;
      logic        to;
      int unsigned hc;
      int unsigned mc;
      int unsigned fc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference model: a wait is pending after any stalled cycle; the watchdog
   // looks at the length of the current run of stalled cycles.
   bit          m_waiting = 1'b0;
   int          m_streak  = 0;
   bit          m_tout    = 1'b0;
   int unsigned m_bub     = 0;
   int unsigned m_fa      = 0;
   int unsigned m_fl      = 0;

   task automatic chk(input string nm, input logic act, input logic req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, req, $time);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input int unsigned req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
      end
   endtask

   task automatic step(input bit r, input bit h, input bit b, input bit rd, input bit wr,
                       input bit rdy);
      exp_t e;
      bit   stalled;
      @(negedge clk);
      rst          = r;
      hazard       = h;
      branch_taken = b;
      mem_r_en     = rd;
      mem_w_en     = wr;
      mem_ready    = rdy;
      #1;
      if (!r) begin
         m_waiting = 1'b0;
         m_streak  = 0;
         m_tout    = 1'b0;
         m_bub     = 0;
         m_fa      = 0;
         m_fl      = 0;
      end
      stalled = r && (rd || wr || m_waiting) && !rdy;
      e.fa    = stalled;
      e.fl    = r && b && !stalled;
      e.bid   = r && h && !b && !stalled;
      e.fif   = stalled || e.bid;
      e.to    = m_tout;
      e.hc    = m_bub;
      e.mc    = m_fa;
      e.fc    = m_fl;
      exp_q.push_back(e);
      if (r) begin
         m_waiting = stalled;
         m_streak  = stalled ? m_streak + 1 : 0;
         if (m_streak >= int'(T_OUT)) m_tout = 1'b1;
         if (e.bid) m_bub++;
         if (e.fa)  m_fa++;
         if (e.fl)  m_fl++;
      end
   endtask

   // Monitor: control outputs are valid every cycle, sampled late in the low phase.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("freeze_if", freeze_if, e.fif);
            chk("bubble_id", bubble_id, e.bid);
            chk("flush", flush, e.fl);
            chk("freeze_all", freeze_all, e.fa);
            chk("mem_timeout", mem_timeout, e.to);
`ifdef PIPE_STALL_CNT_EN
            chk32("hazard_stall_cnt", hazard_stall_cnt, e.hc);
            chk32("mem_stall_cnt", mem_stall_cnt, e.mc);
            chk32("flush_cnt", flush_cnt, e.fc);
`endif
         end
      end
   end

   initial begin
      // reset state
      repeat (3) step(0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      // two-cycle hazard, then hazard together with branch
      repeat (2) step(1, 1, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 1);
      step(1, 1, 1, 0, 0, 1);
      // single-cycle access
      step(1, 0, 0, 1, 0, 1);
      step(1, 0, 0, 0, 1, 1);
      // three wait cycles on a read
      repeat (3) step(1, 0, 0, 1, 0, 0);
      step(1, 0, 0, 1, 0, 1);
      step(1, 0, 0, 0, 0, 1);
      // branch held across a two-cycle write wait
      repeat (2) step(1, 1, 1, 0, 1, 0);
      step(1, 1, 1, 0, 1, 1);
      step(1, 0, 0, 0, 0, 1);
      // watchdog: six stalled cycles against a limit of four
      repeat (6) step(1, 0, 0, 1, 0, 0);
      step(1, 0, 0, 1, 0, 1);
      repeat (2) step(1, 0, 0, 0, 0, 0);
      // reset in the second cycle of a wait, request still pending
      step(1, 0, 0, 1, 0, 0);
      step(0, 1, 1, 1, 0, 0);
      repeat (2) step(1, 0, 0, 1, 0, 0);
      step(1, 0, 1, 1, 0, 1);
      step(1, 0, 0, 0, 0, 0);
      // random traffic with occasional long waits and resets
      for (int i = 0; i < 800; i++) begin
         step(($urandom_range(0, 59) != 0),
              ($urandom_range(0, 99) < 30),
              ($urandom_range(0, 99) < 20),
              ($urandom_range(0, 99) < 35),
              ($urandom_range(0, 99) < 25),
              ($urandom_range(0, 99) < ((i % 100) < 20 ? 10 : 55)));
      end
      repeat (3) @(negedge clk);
      #5;
      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
